key_debounce_fsm: RTL and testbench
===================================

Name: key_debounce_fsm

Overview:
- Consumer end of the sample-tick interface: takes a raw asynchronous push-button and a one-cycle sample strobe from the team's mod-M tick generator.
- Outputs a clean debounced level plus single-cycle press, release and long-press events.
- One instance per key, between the board pins and the alarm-clock control FSM.

Parameters:
- STABLE_TICKS, 4: consecutive agreeing samples needed to accept a level change; must be ≥ 2.
- LONG_TICKS, 100: sample ticks the key must stay accepted-pressed before long_press fires; must be ≥ 1.
- ACTIVE_LOW, 1: 1 means key_in = 0 is pressed; 0 means key_in = 1 is pressed.
- Derived localparams: SW = $clog2(STABLE_TICKS+1), LW = $clog2(LONG_TICKS+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick_in  in  1  sample strobe from the tick generator; one clk wide, any period (may be held high)
- key_in  in  1  raw asynchronous button level
- key_level  out  1  debounced level; 1 = pressed
- press_pulse  out  1  one-cycle pulse on accepted press
- release_pulse  out  1  one-cycle pulse on accepted release
- long_press  out  1  one-cycle pulse, at most once per accepted press

Behaviour:
- Reset values (rst_n = 0 at a clk edge):
  - All outputs 0.
  - State IDLE; stable counter and hold counter 0.
  - Synchronizer flops at the released level (ACTIVE_LOW ? 1 : 0).
  - Reset mid-debounce or mid-press aborts silently; no release_pulse is emitted.
- Input conditioning: 2-FF synchronizer, then pressed = ACTIVE_LOW ? ~sync : sync. This adds 2 clk of latency before a sample can see a change.
- Sampling rule: pressed is examined only in cycles with tick_in = 1; all other cycles leave state and counters unchanged.
- States:
  - IDLE (released):
    - On tick with pressed = 1: go to WAIT_PRESS, scnt ← 1.
    - Otherwise stay.
  - WAIT_PRESS:
    - On tick with pressed = 0: go to IDLE, scnt ← 0 (bounce rejected).
    - On tick with pressed = 1 and scnt = STABLE_TICKS−1: go to PRESSED, scnt ← 0, hcnt ← 0.
    - Otherwise scnt++.
  - PRESSED:
    - On tick with pressed = 0: go to WAIT_RELEASE, scnt ← 1.
    - On tick with pressed = 1: hcnt++ saturating at LONG_TICKS. If hcnt = LONG_TICKS−1 before the increment, long_press fires.
  - WAIT_RELEASE:
    - On tick with pressed = 1: go to PRESSED, scnt ← 0. hcnt is preserved; it is not incremented on this tick.
    - On tick with pressed = 0 and scnt = STABLE_TICKS−1: go to IDLE, scnt ← 0, hcnt ← 0.
    - Otherwise scnt++.
- Registered outputs; all update on the same edge as the state transition:
  - key_level = 1 in PRESSED and WAIT_RELEASE, 0 otherwise.
  - press_pulse is high for exactly one clk after the WAIT_PRESS→PRESSED edge.
  - release_pulse is high for exactly one clk after the WAIT_RELEASE→IDLE edge.
  - long_press is high for exactly one clk; hcnt saturation prevents a repeat until the next accepted press.
- Latency: a clean press is accepted on the STABLE_TICKS-th tick after the synchronized edge. Its outputs are visible the following cycle.
- tick_in held high continuously: every clk counts as a sample, which is legal.
- No two event pulses are ever high in the same cycle.

Decomposition:
- Shared package key_pkg:
  - State encoding constants: IDLE = 2'd0, WAIT_PRESS = 2'd1, PRESSED = 2'd2, WAIT_RELEASE = 2'd3.
  - Default constants for STABLE_TICKS and LONG_TICKS.
- One sub-module: sync_2ff, parameterized reset value; reused for other async inputs.
- The tick source stays external so one generator can feed all keys.

Test Plan:
- Setup for all cases: STABLE_TICKS = 4, LONG_TICKS = 5, ACTIVE_LOW = 1, tick every 10 clk.
- Clean press: key_in 1→0 and held → press_pulse one cycle after the 4th tick following the synchronized edge; key_level = 1 from that cycle; no other pulse.
- Bounce reject: key_in low for 2 ticks, high for 1 tick, then low and held → the counter restarts; press_pulse only after 4 further consecutive low ticks; exactly one press_pulse.
- Long press and release: hold pressed → long_press exactly once on the 5th tick after acceptance, no repeat over 20 more ticks. Release cleanly → release_pulse after 4 high ticks; key_level = 0.
- Release bounce: during WAIT_RELEASE, 1 tick high, then low again → return to PRESSED; key_level stays 1; no release_pulse; long_press does not refire.
- Reset mid-operation: assert rst_n = 0 for 1 clk while PRESSED → next cycle all outputs 0, state IDLE, no release_pulse. A fresh 4-tick press is required to reassert key_level.
- Continuous tick: tick_in = 1 constantly; key_in low for 3 clk then high → nothing accepted. key_in low for 6 clk → press_pulse at clk 2 + 4 + 1 after the edge.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: state encoding and
// default tick counts.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } key_state_t;

    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_LONG_TICKS   = 100;

endpackage : key_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; the reset value is
// a parameter so each input can come up at its own idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: every register here is written with <= so both flops sample the
    // pre-edge values; a blocking assignment would collapse the two stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/key_debounce_fsm.sv
// Per-key debouncer: synchronizes a raw button, accepts level changes only
// after STABLE_TICKS agreeing samples, and emits press/release/long-press events.
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int LW = $clog2(LONG_TICKS + 1);

    localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [LW-1:0] H_LAST = LW'(LONG_TICKS - 1);
    localparam logic [LW-1:0] H_MAX  = LW'(LONG_TICKS);
    localparam logic [LW-1:0] H_ONE  = LW'(1);

    key_state_t    state;
    logic [SW-1:0] scnt;
    logic [LW-1:0] hcnt;
    logic          sync_q;
    logic          pressed;

    // Synchronizer idles at the released level so reset never looks like a press.
    sync_2ff #(
        .RST_VAL (ACTIVE_LOW ? 1'b1 : 1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (sync_q)
    );

    assign pressed = ACTIVE_LOW ? ~sync_q : sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            scnt          <= '0;
            hcnt          <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            // Event outputs default low so each fires for a single cycle.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            if (tick_in) begin
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            state <= WAIT_PRESS;
                            scnt  <= S_ONE;
                        end
                    end

                    WAIT_PRESS: begin
                        if (!pressed) begin
                            state <= IDLE;
                            scnt  <= '0;
                        end else if (scnt == S_LAST) begin
                            state       <= PRESSED;
                            scnt        <= '0;
                            hcnt        <= '0;
                            key_level   <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            scnt <= scnt + S_ONE;
                        end
                    end

                    PRESSED: begin
                        if (!pressed) begin
                            state <= WAIT_RELEASE;
                            scnt  <= S_ONE;
                        end else if (hcnt != H_MAX) begin
                            // Saturation at H_MAX keeps long_press to one shot per press.
                            hcnt       <= hcnt + H_ONE;
                            long_press <= (hcnt == H_LAST);
                        end
                    end

                    WAIT_RELEASE: begin
                        if (pressed) begin
                            state <= PRESSED;
                            scnt  <= '0;
                        end else if (scnt == S_LAST) begin
                            state         <= IDLE;
                            scnt          <= '0;
                            hcnt          <= '0;
                            key_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            scnt <= scnt + S_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule : key_debounce_fsm

// File: tb/tb_key_debounce_fsm.sv
// Self-checking bench for key_debounce_fsm: hand-derived vector table,
// directed multi-cycle sequences, and randomized stimulus against a run-length model.
module tb_key_debounce_fsm;

    localparam int STABLE = 4;
    localparam int LONG   = 5;
    localparam bit ALOW   = 1'b1;
    localparam logic REL_KEY = ALOW ? 1'b1 : 1'b0;

    logic clk = 1'b0;
    logic rst_n, tick_in, key_in;
    logic key_level, press_pulse, release_pulse, long_press;

    key_debounce_fsm #(
        .STABLE_TICKS (STABLE),
        .LONG_TICKS   (LONG),
        .ACTIVE_LOW   (ALOW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_in       (tick_in),
        .key_in        (key_in),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int period = 10;
    int press_cnt = 0, rel_cnt = 0, long_cnt = 0;

    // Reference model: accepted level flips after STABLE consecutive opposite
    // samples; hold count = pressed samples preceded by a pressed sample.
    logic m_kd0, m_kd1;
    logic m_level, m_prev, m_press, m_rel, m_long;
    int   m_run, m_hold;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=%b expected=%b (level,press,release,long)",
                         name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic t, input logic k);
        logic p;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!r) begin
            m_kd0 = REL_KEY;
            m_kd1 = REL_KEY;
            m_level = 1'b0;
            m_prev  = 1'b0;
            m_run   = 0;
            m_hold  = 0;
            return;
        end
        p = (m_kd1 != REL_KEY);
        m_kd1 = m_kd0;
        m_kd0 = k;
        if (!t) return;
        if (m_level && p && m_prev && m_hold < LONG) begin
            m_hold++;
            if (m_hold == LONG) m_long = 1'b1;
        end
        m_prev = p;
        if (p != m_level) begin
            m_run++;
            if (m_run == STABLE) begin
                m_level = p;
                m_run = 0;
                if (p) begin
                    m_press = 1'b1;
                    m_hold  = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    function automatic logic [3:0] outs();
        return {key_level, press_pulse, release_pulse, long_press};
    endfunction

    // One clock: drive, clock edge, update model, sample 1 time unit later.
    task automatic step(input logic r, input logic t, input logic k);
        rst_n   = r;
        tick_in = t;
        key_in  = k;
        @(posedge clk);
        model_update(r, t, k);
        #1;
        check("model", outs(), {m_level, m_press, m_rel, m_long});
        if (press_pulse)   press_cnt++;
        if (release_pulse) rel_cnt++;
        if (long_press)    long_cnt++;
        cyc++;
    endtask

    task automatic run(input int n, input logic k);
        for (int i = 0; i < n; i++)
            step(1'b1, (cyc % period) == 0, k);
    endtask

    typedef struct {
        logic       rst;
        logic       tick;
        logic       key;
        int         n;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Continuous tick; key pressed = 0. Expected {level,press,release,long}.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1, 4'b0000});  // reset
        vecs.push_back('{1'b1, 1'b1, 1'b0, 5, 4'b0000});  // sync latency + 3 samples
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 4'b1100});  // 4th sample: press
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4, 4'b1000});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 4'b1001});  // 5th held sample: long
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 4'b1000});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 5, 4'b1000});  // release debouncing
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1, 4'b0010});  // release accepted
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1, 4'b0000});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 4'b0000});  // 3-clk glitch
        vecs.push_back('{1'b1, 1'b1, 1'b1, 6, 4'b0000});  // rejected

        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                step(vecs[v].rst, vecs[v].tick, vecs[v].key);
                check($sformatf("table[%0d]", v), outs(), vecs[v].exp);
            end
        end

        // Directed sequences, tick every 10 clk.
        period = 10;
        step(1'b0, 1'b0, 1'b1);
        check("reset_outputs", outs(), 4'b0000);
        run(40, 1'b1);
        press_cnt = 0; rel_cnt = 0; long_cnt = 0;

        // Bounce reject: 2 low ticks, 1 high tick, then held low.
        run(20, 1'b0);
        run(10, 1'b1);
        check_int("bounce_no_early_press", press_cnt, 0);
        run(30, 1'b0);
        check_int("bounce_not_yet", press_cnt, 0);
        run(30, 1'b0);
        check_int("bounce_one_press", press_cnt, 1);
        check("bounce_level", outs() & 4'b1000, 4'b1000);

        // Long press once, never repeated.
        run(60, 1'b0);
        check_int("long_once", long_cnt, 1);
        run(200, 1'b0);
        check_int("long_no_repeat", long_cnt, 1);

        // Release bounce: back to pressed, no release, no second long press.
        run(20, 1'b1);
        run(10, 1'b0);
        check("rel_bounce_level", outs() & 4'b1000, 4'b1000);
        run(100, 1'b0);
        check_int("rel_bounce_no_release", rel_cnt, 0);
        check_int("rel_bounce_no_long", long_cnt, 1);

        // Clean release.
        run(60, 1'b1);
        check_int("release_once", rel_cnt, 1);
        check("release_level", outs(), 4'b0000);

        // Reset while pressed: silent abort, fresh press required.
        run(60, 1'b0);
        check("pressed_again", outs() & 4'b1000, 4'b1000);
        rel_cnt = 0;
        step(1'b0, 1'b0, 1'b0);
        check("reset_mid_press", outs(), 4'b0000);
        run(30, 1'b0);
        check("reset_needs_fresh_press", outs() & 4'b1000, 4'b0000);
        run(40, 1'b0);
        check("fresh_press_level", outs() & 4'b1000, 4'b1000);
        check_int("reset_no_release", rel_cnt, 0);

        // Randomized: varying tick density, hold lengths, occasional reset.
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            logic k;
            case ($urandom_range(0, 3))
                0: period = 1;
                1: period = 2;
                2: period = 5;
                default: period = 10;
            endcase
            len = $urandom_range(1, 40);
            k = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 30) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), k);
            run(len, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_debounce_fsm
